alu_writeback: RTL

//  Downstream consumer of the ALU output stage. Captures each acknowledged result
//  (alu_ack pulse with alu_out and C/N/Z/V) into an in-order FIFO. Drains the FIFO
//  to the register-file write port under a valid/ready handshake.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 71 +++++++
 rtl/alu_writeback.sv | 105 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU writeback slice: widths, flag bit positions
// and the packed layout of one queued writeback entry.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NFLAGS = 4;

    // Bit positions inside the {N,Z,C,V} flag nibble.
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic              flag_en;
        logic [NFLAGS-1:0] flags;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO with registered storage, flush, and a
// combinational head read. Full/empty come from the occupancy count.
module wb_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W:0]   o_count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A push into a full FIFO is accepted only when a pop frees the slot.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/alu_writeback.sv
// Queues acknowledged ALU results in order and drains them to the register
// file, committing status flags only when an entry is actually written back.
module alu_writeback
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              alu_ack,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              cf,
    input  logic              nf,
    input  logic              zf,
    input  logic              vf,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic              wb_flag_en,
    input  logic              flush,
    input  logic              clr_err,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    input  logic              rf_wr_rdy,
    output logic [3:0]        flags_q,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              ovf_err
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    wb_entry_t         w_new;
    wb_entry_t         w_head;
    logic [NFLAGS-1:0] w_new_flags;
    logic              w_full;
    logic              w_empty;
    logic [PTR_W:0]    w_count;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf;

    logic [3:0]        r_flags;
    logic              r_ovf_err;

    always_comb begin
        w_new_flags        = '0;
        w_new_flags[FLG_N] = nf;
        w_new_flags[FLG_Z] = zf;
        w_new_flags[FLG_C] = cf;
        w_new_flags[FLG_V] = vf;
    end

    assign w_new = '{dest: wb_dest, flag_en: wb_flag_en, flags: w_new_flags, data: alu_out};

    // rf_wr_en is valid, rf_wr_rdy is ready: a write transfers on a cycle where
    // both are high. While valid is high and ready low, addr/data hold the head.
    assign w_pop  = rf_wr_en && rf_wr_rdy;
    assign w_push = alu_ack && (!w_full || w_pop);
    assign w_ovf  = alu_ack && w_full && !w_pop;

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_b   (rst_b),
        .i_push  (w_push),
        .i_data  (w_new),
        .i_pop   (w_pop),
        .i_flush (flush),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_flags <= '0;
        end else if (w_pop && !flush && w_head.flag_en) begin
            r_flags <= w_head.flags;
        end
    end

    // A new overflow in the same cycle as clr_err keeps the error set.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ovf_err <= 1'b0;
        end else if (w_ovf) begin
            r_ovf_err <= 1'b1;
        end else if (clr_err) begin
            r_ovf_err <= 1'b0;
        end
    end

    assign rf_wr_en   = !w_empty;
    assign rf_wr_addr = w_head.dest;
    assign rf_wr_data = w_head.data;
    assign flags_q    = r_flags;
    assign ovf_err    = r_ovf_err;
    assign fifo_full  = (w_count == FULL_CNT);
    assign fifo_empty = (w_count == '0);

endmodule
